switch_seq_ctrl: RTL and testbench
==================================

Name: switch_seq_ctrl

Overview:
- Programmable sequencer that drives the lane-switch and gate control pulses into the simple_tx traffic generator: ext_rst_count, ext_switch_lane0/1_on, ext_switch_lane0/1_done and ext_gate_ctrl.
- Replaces hand-timed pulse generation. Issues a fixed pulse order with configurable cycle gaps, repeats it for N rounds, and captures global timestamps at key events.
- Sits between the control-register block and simple_tx, in the aclk domain.

Parameters:
- CNT_WIDTH, 16, width of every delay config field and of the internal down-counter.
- TIMESTAMP_WIDTH, 64, width of stamp_counter and of the captured timestamps.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  reset, synchronous, active-low.
- start  in  1  launches a sequence; sampled in IDLE only.
- abort  in  1  terminates the sequence immediately.
- cfg_rst_delay  in  CNT_WIDTH  idle cycles from the rst pulse to lane0_on.
- cfg_on_done_delay  in  CNT_WIDTH  idle cycles from laneX_on to laneX_done.
- cfg_lane_gap  in  CNT_WIDTH  idle cycles from lane0_done to lane1_on, and from gate to the next round's lane0_on.
- cfg_gate_delay  in  CNT_WIDTH  idle cycles from lane1_done to gate.
- cfg_rounds  in  8  number of rounds; 0 is treated as 1.
- stamp_counter  in  TIMESTAMP_WIDTH  free-running global time.
- ext_rst_count  out  1  one-cycle pulse.
- ext_switch_lane0_on  out  1  one-cycle pulse.
- ext_switch_lane0_done  out  1  one-cycle pulse.
- ext_switch_lane1_on  out  1  one-cycle pulse.
- ext_switch_lane1_done  out  1  one-cycle pulse.
- ext_gate_ctrl  out  1  one-cycle pulse.
- busy  out  1  high while a sequence is active.
- seq_done  out  1  one-cycle pulse on normal completion.
- round_cnt  out  8  completed rounds in the current or last sequence.
- ts_lane0_on  out  TIMESTAMP_WIDTH  stamp at the most recent lane0_on.
- ts_lane1_done  out  TIMESTAMP_WIDTH  stamp at the most recent lane1_done.

Behaviour:
- All outputs are registered. Reset value of every output is 0.
- States: IDLE, P_RST, W_RST, P_L0ON, W_L0, P_L0DN, W_GAP, P_L1ON, W_L1, P_L1DN, W_GATE, P_GATE, W_NEXT.
- Each P_* state lasts exactly one cycle and asserts only its own pulse output.
- Each W_* state loads the down-counter with its delay D on entry and lasts exactly D cycles. D=0 skips the wait state entirely.
- Pulse timing rule: if a pulse is at cycle p, the next pulse is at cycle p+D+1.
- Config latch: cfg_* values are latched when start is accepted. Later changes have no effect until the next start.
- Start: with start=1 in IDLE at edge k, the state moves to P_RST, so ext_rst_count and busy are high in cycle k+1.
- Pulse order per sequence: P_RST (first round only) -> W_RST -> P_L0ON -> W_L0 -> P_L0DN -> W_GAP -> P_L1ON -> W_L1 -> P_L1DN -> W_GATE -> P_GATE.
- After P_GATE, round_cnt increments:
  - If round_cnt < max(cfg_rounds,1), go to W_NEXT (cfg_lane_gap cycles) then P_L0ON.
  - Otherwise go to IDLE. seq_done is high for one cycle and busy is low in that same cycle.
- round_cnt clears to 0 on start acceptance and holds its value after completion.
- Timestamps: ts_lane0_on and ts_lane1_done load stamp_counter on the same edge that asserts the respective pulse. They hold their value otherwise.
- start while busy: ignored, with no effect on state or config.
- abort, in any non-IDLE state: on the next edge the state returns to IDLE, all pulses are 0, busy is 0, no seq_done is issued, and round_cnt and timestamps hold.
- abort has priority over start in IDLE.
- aresetn=0 mid-sequence: everything returns to reset values on the next edge.
- Pulse exclusivity: at most one ext_* pulse is high in any cycle.

Test Plan:
1. rst_delay=9, on_done=2, lane_gap=9, gate_delay=1, rounds=1, start at edge T.
   - Required: ext_rst_count at T+1, lane0_on at T+11, lane0_done at T+14, lane1_on at T+24, lane1_done at T+27, gate at T+29.
   - Required: seq_done at T+30; busy high over T+1..T+29; round_cnt=1.
2. All delays 0, rounds=1 -> six pulses in consecutive cycles T+1..T+6, seq_done at T+7.
3. Same config as (1), rounds=3.
   - Required: second lane0_on at T+39, one seq_done only, round_cnt=3.
   - Required: ts_lane0_on equals stamp_counter at the third lane0_on.
4. Abort at T+15 during the (1) config -> all outputs low from T+16, no seq_done. A new start at T+20 restarts cleanly with ext_rst_count at T+21.
5. start pulsed at T+5 while busy, with changed cfg -> pulse timing identical to (1).
6. aresetn=0 at T+12 -> all outputs 0 at T+13 and IDLE; rounds=0 -> behaves as rounds=1.

Source files
------------

// File: rtl/switch_seq_ctrl_if.sv
// Control/status bundle between the control-register block, the sequencer
// and the simple_tx pulse inputs.
interface switch_seq_ctrl_if #(
  parameter int CNT_WIDTH       = 16,
  parameter int TIMESTAMP_WIDTH = 64
) ();
  logic                       start;
  logic                       abort;
  logic [CNT_WIDTH-1:0]       cfg_rst_delay;
  logic [CNT_WIDTH-1:0]       cfg_on_done_delay;
  logic [CNT_WIDTH-1:0]       cfg_lane_gap;
  logic [CNT_WIDTH-1:0]       cfg_gate_delay;
  logic [7:0]                 cfg_rounds;
  logic [TIMESTAMP_WIDTH-1:0] stamp_counter;

  logic                       ext_rst_count;
  logic                       ext_switch_lane0_on;
  logic                       ext_switch_lane0_done;
  logic                       ext_switch_lane1_on;
  logic                       ext_switch_lane1_done;
  logic                       ext_gate_ctrl;
  logic                       busy;
  logic                       seq_done;
  logic [7:0]                 round_cnt;
  logic [TIMESTAMP_WIDTH-1:0] ts_lane0_on;
  logic [TIMESTAMP_WIDTH-1:0] ts_lane1_done;

  modport master (
    output start, abort, cfg_rst_delay, cfg_on_done_delay, cfg_lane_gap,
           cfg_gate_delay, cfg_rounds, stamp_counter,
    input  ext_rst_count, ext_switch_lane0_on, ext_switch_lane0_done,
           ext_switch_lane1_on, ext_switch_lane1_done, ext_gate_ctrl,
           busy, seq_done, round_cnt, ts_lane0_on, ts_lane1_done
  );

  modport slave (
    input  start, abort, cfg_rst_delay, cfg_on_done_delay, cfg_lane_gap,
           cfg_gate_delay, cfg_rounds, stamp_counter,
    output ext_rst_count, ext_switch_lane0_on, ext_switch_lane0_done,
           ext_switch_lane1_on, ext_switch_lane1_done, ext_gate_ctrl,
           busy, seq_done, round_cnt, ts_lane0_on, ts_lane1_done
  );
endinterface

// File: rtl/switch_seq_ctrl.sv
// Lane-switch / gate pulse sequencer for simple_tx. Emits a fixed pulse
// order with programmable gaps, repeats for cfg_rounds rounds and stamps
// the lane0_on and lane1_done events with the global time counter.
module switch_seq_ctrl #(
  parameter int CNT_WIDTH       = 16,
  parameter int TIMESTAMP_WIDTH = 64
) (
  input  logic              aclk,
  input  logic              aresetn,
  switch_seq_ctrl_if.slave  bus
);

  typedef enum logic [3:0] {
    IDLE, P_RST, W_RST, P_L0ON, W_L0, P_L0DN, W_GAP,
    P_L1ON, W_L1, P_L1DN, W_GATE, P_GATE, W_NEXT
  } state_t;

  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

  state_t                     r_state;
  logic [CNT_WIDTH-1:0]       r_cnt;
  logic [CNT_WIDTH-1:0]       r_rst_dly, r_on_done_dly, r_lane_gap, r_gate_dly;
  logic [7:0]                 r_rounds;
  logic                       r_rst_count, r_l0_on, r_l0_done, r_l1_on, r_l1_done, r_gate;
  logic                       r_busy, r_seq_done;
  logic [7:0]                 r_round_cnt;
  logic [TIMESTAMP_WIDTH-1:0] r_ts_l0_on, r_ts_l1_done;

  state_t                     w_nxt;
  logic                       w_ld;
  logic [CNT_WIDTH-1:0]       w_ld_val;
  logic                       w_fin;
  logic                       w_more;

  // Another round follows if the count after this gate is still below the target.
  assign w_more = ({1'b0, r_round_cnt} + 9'd1) < {1'b0, r_rounds};

  // Next-state decode; each pulse state either enters its wait or, for a
  // zero delay, jumps straight to the following pulse.
  always_comb begin
    w_nxt    = r_state;
    w_ld     = 1'b0;
    w_ld_val = '0;
    w_fin    = 1'b0;
    unique case (r_state)
      IDLE:   if (bus.start) w_nxt = P_RST;
      P_RST:  begin
                w_ld = 1'b1; w_ld_val = r_rst_dly - ONE;
                w_nxt = (r_rst_dly == '0) ? P_L0ON : W_RST;
              end
      W_RST:  if (r_cnt == '0) w_nxt = P_L0ON;
      P_L0ON: begin
                w_ld = 1'b1; w_ld_val = r_on_done_dly - ONE;
                w_nxt = (r_on_done_dly == '0) ? P_L0DN : W_L0;
              end
      W_L0:   if (r_cnt == '0) w_nxt = P_L0DN;
      P_L0DN: begin
                w_ld = 1'b1; w_ld_val = r_lane_gap - ONE;
                w_nxt = (r_lane_gap == '0) ? P_L1ON : W_GAP;
              end
      W_GAP:  if (r_cnt == '0) w_nxt = P_L1ON;
      P_L1ON: begin
                w_ld = 1'b1; w_ld_val = r_on_done_dly - ONE;
                w_nxt = (r_on_done_dly == '0) ? P_L1DN : W_L1;
              end
      W_L1:   if (r_cnt == '0) w_nxt = P_L1DN;
      P_L1DN: begin
                w_ld = 1'b1; w_ld_val = r_gate_dly - ONE;
                w_nxt = (r_gate_dly == '0) ? P_GATE : W_GATE;
              end
      W_GATE: if (r_cnt == '0) w_nxt = P_GATE;
      P_GATE: begin
                if (w_more) begin
                  w_ld = 1'b1; w_ld_val = r_lane_gap - ONE;
                  w_nxt = (r_lane_gap == '0) ? P_L0ON : W_NEXT;
                end else begin
                  w_nxt = IDLE;
                  w_fin = 1'b1;
                end
              end
      W_NEXT: if (r_cnt == '0) w_nxt = P_L0ON;
      default: w_nxt = IDLE;
    endcase
    // abort wins everywhere, including over start in IDLE
    if (bus.abort) begin
      w_nxt = IDLE;
      w_ld  = 1'b0;
      w_fin = 1'b0;
    end
  end

  // State, wait counter, config latch and registered outputs.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_rst_dly     <= '0;
      r_on_done_dly <= '0;
      r_lane_gap    <= '0;
      r_gate_dly    <= '0;
      r_rounds      <= '0;
      r_rst_count   <= 1'b0;
      r_l0_on       <= 1'b0;
      r_l0_done     <= 1'b0;
      r_l1_on       <= 1'b0;
      r_l1_done     <= 1'b0;
      r_gate        <= 1'b0;
      r_busy        <= 1'b0;
      r_seq_done    <= 1'b0;
      r_round_cnt   <= '0;
      r_ts_l0_on    <= '0;
      r_ts_l1_done  <= '0;
    end else begin
      r_state <= w_nxt;
      if (w_ld)              r_cnt <= w_ld_val;
      else if (r_cnt != '0)  r_cnt <= r_cnt - ONE;

      r_rst_count <= (w_nxt == P_RST);
      r_l0_on     <= (w_nxt == P_L0ON);
      r_l0_done   <= (w_nxt == P_L0DN);
      r_l1_on     <= (w_nxt == P_L1ON);
      r_l1_done   <= (w_nxt == P_L1DN);
      r_gate      <= (w_nxt == P_GATE);
      r_busy      <= (w_nxt != IDLE);
      r_seq_done  <= w_fin;

      if (r_state == IDLE && w_nxt == P_RST) begin
        r_rst_dly     <= bus.cfg_rst_delay;
        r_on_done_dly <= bus.cfg_on_done_delay;
        r_lane_gap    <= bus.cfg_lane_gap;
        r_gate_dly    <= bus.cfg_gate_delay;
        r_rounds      <= (bus.cfg_rounds == '0) ? 8'd1 : bus.cfg_rounds;
        r_round_cnt   <= '0;
      end else if (r_state == P_GATE && !bus.abort) begin
        r_round_cnt   <= r_round_cnt + 8'd1;
      end

      if (w_nxt == P_L0ON) r_ts_l0_on   <= bus.stamp_counter;
      if (w_nxt == P_L1DN) r_ts_l1_done <= bus.stamp_counter;
    end
  end

  assign bus.ext_rst_count         = r_rst_count;
  assign bus.ext_switch_lane0_on   = r_l0_on;
  assign bus.ext_switch_lane0_done = r_l0_done;
  assign bus.ext_switch_lane1_on   = r_l1_on;
  assign bus.ext_switch_lane1_done = r_l1_done;
  assign bus.ext_gate_ctrl         = r_gate;
  assign bus.busy                  = r_busy;
  assign bus.seq_done              = r_seq_done;
  assign bus.round_cnt             = r_round_cnt;
  assign bus.ts_lane0_on           = r_ts_l0_on;
  assign bus.ts_lane1_done         = r_ts_l1_done;

endmodule

// File: tb/tb_switch_seq_ctrl.sv
// Directed bench for switch_seq_ctrl. Cycle n of a trace is the n-th clock
// period after the edge that samples start; outputs are sampled on negedges.
module tb_switch_seq_ctrl;
  localparam int CW = 16;
  localparam int TW = 64;
  localparam int NMAX = 128;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  switch_seq_ctrl_if #(.CNT_WIDTH(CW), .TIMESTAMP_WIDTH(TW)) bus ();

  switch_seq_ctrl #(.CNT_WIDTH(CW), .TIMESTAMP_WIDTH(TW)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  // {seq_done, busy, gate, l1_done, l1_on, l0_done, l0_on, rst_count}
  logic [7:0]    tr_v     [0:NMAX-1];
  logic [7:0]    exp_v    [0:NMAX-1];
  logic [7:0]    tr_round [0:NMAX-1];
  logic [TW-1:0] tr_ts0   [0:NMAX-1];
  logic [TW-1:0] tr_ts1   [0:NMAX-1];
  logic [TW-1:0] tr_stamp [0:NMAX-1];
  logic [TW-1:0] g_stamp = 64'h0123_4567_0000_0000;

  task automatic set_cfg(input int rd, input int od, input int lg, input int gd, input int rn);
    bus.cfg_rst_delay     = CW'(rd);
    bus.cfg_on_done_delay = CW'(od);
    bus.cfg_lane_gap      = CW'(lg);
    bus.cfg_gate_delay    = CW'(gd);
    bus.cfg_rounds        = 8'(rn);
  endtask

  // Pulse start in cycle 0, then record ncyc cycles; abort/start/reset are
  // asserted during the named cycle (-1 = never).
  task automatic run_seq(input int ncyc, input int abort_at, input int start_at,
                         input int rst_at, input bit alt);
    @(negedge aclk);
    bus.start = 1'b1;
    g_stamp = g_stamp + 64'd3;
    bus.stamp_counter = g_stamp;
    tr_stamp[0] = g_stamp;
    for (int n = 1; n <= ncyc; n++) begin
      @(negedge aclk);
      tr_v[n] = {bus.seq_done, bus.busy, bus.ext_gate_ctrl, bus.ext_switch_lane1_done,
                 bus.ext_switch_lane1_on, bus.ext_switch_lane0_done,
                 bus.ext_switch_lane0_on, bus.ext_rst_count};
      tr_round[n] = bus.round_cnt;
      tr_ts0[n]   = bus.ts_lane0_on;
      tr_ts1[n]   = bus.ts_lane1_done;
      bus.start = (n == start_at);
      bus.abort = (n == abort_at);
      aresetn   = !(n == rst_at);
      if (alt && n == start_at) set_cfg(0, 0, 0, 0, 5);
      g_stamp = g_stamp + 64'd3;
      bus.stamp_counter = g_stamp;
      tr_stamp[n] = g_stamp;
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
    aresetn   = 1'b1;
  endtask

  task automatic clr_exp();
    for (int n = 0; n < NMAX; n++) exp_v[n] = '0;
  endtask

  task automatic exp_busy(input int a, input int b);
    for (int n = a; n <= b; n++) exp_v[n][6] = 1'b1;
  endtask

  // Pulses of one round for the 9/2/9/1 configuration, lane0_on at cycle c.
  task automatic exp_round(input int c);
    exp_v[c][1] = 1'b1;
    exp_v[c+3][2] = 1'b1;
    exp_v[c+13][3] = 1'b1;
    exp_v[c+16][4] = 1'b1;
    exp_v[c+18][5] = 1'b1;
  endtask

  task automatic build_basic();
    clr_exp();
    exp_v[1][0] = 1'b1;
    exp_round(11);
    exp_busy(1, 29);
    exp_v[30][7] = 1'b1;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.stamp_counter = g_stamp;
    set_cfg(9, 2, 9, 1, 1);
    repeat (3) @(negedge aclk);
    vectors++;
    if ({bus.seq_done, bus.busy, bus.ext_gate_ctrl, bus.ext_switch_lane1_done,
         bus.ext_switch_lane1_on, bus.ext_switch_lane0_done, bus.ext_switch_lane0_on,
         bus.ext_rst_count} !== 8'h00) begin
      miscompares++; $display("FAIL reset_ctrl: got nonzero control outputs");
    end
    vectors++;
    if (bus.round_cnt !== 8'd0) begin
      miscompares++; $display("FAIL reset_round: got %0d want 0", bus.round_cnt);
    end
    vectors++;
    if (bus.ts_lane0_on !== '0) begin
      miscompares++; $display("FAIL reset_ts0: got %h want 0", bus.ts_lane0_on);
    end
    vectors++;
    if (bus.ts_lane1_done !== '0) begin
      miscompares++; $display("FAIL reset_ts1: got %h want 0", bus.ts_lane1_done);
    end
    aresetn = 1'b1;
    @(negedge aclk);
  endtask

  task automatic test_basic();
    set_cfg(9, 2, 9, 1, 1);
    run_seq(32, -1, -1, -1, 1'b0);
    build_basic();
    for (int n = 1; n <= 32; n++) begin
      vectors++;
      if (tr_v[n] !== exp_v[n]) begin
        miscompares++; $display("FAIL basic cyc%0d: got %b want %b", n, tr_v[n], exp_v[n]);
      end
    end
    vectors++;
    if (tr_round[31] !== 8'd1) begin
      miscompares++; $display("FAIL basic_round: got %0d want 1", tr_round[31]);
    end
    vectors++;
    if (tr_ts0[31] !== tr_stamp[10]) begin
      miscompares++; $display("FAIL basic_ts0: got %h want %h", tr_ts0[31], tr_stamp[10]);
    end
    vectors++;
    if (tr_ts1[31] !== tr_stamp[26]) begin
      miscompares++; $display("FAIL basic_ts1: got %h want %h", tr_ts1[31], tr_stamp[26]);
    end
  endtask

  task automatic test_zero_delay();
    set_cfg(0, 0, 0, 0, 1);
    run_seq(9, -1, -1, -1, 1'b0);
    clr_exp();
    for (int n = 1; n <= 6; n++) exp_v[n][n-1] = 1'b1;
    exp_busy(1, 6);
    exp_v[7][7] = 1'b1;
    for (int n = 1; n <= 9; n++) begin
      vectors++;
      if (tr_v[n] !== exp_v[n]) begin
        miscompares++; $display("FAIL zero cyc%0d: got %b want %b", n, tr_v[n], exp_v[n]);
      end
    end
  endtask

  task automatic test_rounds();
    set_cfg(9, 2, 9, 1, 3);
    run_seq(90, -1, -1, -1, 1'b0);
    clr_exp();
    exp_v[1][0] = 1'b1;
    exp_round(11);
    exp_round(39);
    exp_round(67);
    exp_busy(1, 85);
    exp_v[86][7] = 1'b1;
    for (int n = 1; n <= 90; n++) begin
      vectors++;
      if (tr_v[n] !== exp_v[n]) begin
        miscompares++; $display("FAIL rounds cyc%0d: got %b want %b", n, tr_v[n], exp_v[n]);
      end
    end
    vectors++;
    if (tr_round[30] !== 8'd1) begin
      miscompares++; $display("FAIL rounds_r1: got %0d want 1", tr_round[30]);
    end
    vectors++;
    if (tr_round[58] !== 8'd2) begin
      miscompares++; $display("FAIL rounds_r2: got %0d want 2", tr_round[58]);
    end
    vectors++;
    if (tr_round[90] !== 8'd3) begin
      miscompares++; $display("FAIL rounds_r3: got %0d want 3", tr_round[90]);
    end
    vectors++;
    if (tr_ts0[67] !== tr_stamp[66]) begin
      miscompares++; $display("FAIL rounds_ts0: got %h want %h", tr_ts0[67], tr_stamp[66]);
    end
    vectors++;
    if (tr_ts1[90] !== tr_stamp[82]) begin
      miscompares++; $display("FAIL rounds_ts1: got %h want %h", tr_ts1[90], tr_stamp[82]);
    end
  endtask

  task automatic test_abort();
    set_cfg(9, 2, 9, 1, 1);
    run_seq(50, 15, 20, -1, 1'b0);
    clr_exp();
    exp_v[1][0] = 1'b1;
    exp_v[11][1] = 1'b1;
    exp_v[14][2] = 1'b1;
    exp_busy(1, 15);
    exp_v[21][0] = 1'b1;
    exp_round(31);
    exp_busy(21, 49);
    exp_v[50][7] = 1'b1;
    for (int n = 1; n <= 50; n++) begin
      vectors++;
      if (tr_v[n] !== exp_v[n]) begin
        miscompares++; $display("FAIL abort cyc%0d: got %b want %b", n, tr_v[n], exp_v[n]);
      end
    end
    vectors++;
    if (tr_ts0[18] !== tr_stamp[10]) begin
      miscompares++; $display("FAIL abort_ts0_hold: got %h want %h", tr_ts0[18], tr_stamp[10]);
    end
    vectors++;
    if (tr_round[50] !== 8'd1) begin
      miscompares++; $display("FAIL abort_round: got %0d want 1", tr_round[50]);
    end
  endtask

  task automatic test_back_to_back();
    set_cfg(9, 2, 9, 1, 1);
    run_seq(32, -1, 5, -1, 1'b1);
    build_basic();
    for (int n = 1; n <= 32; n++) begin
      vectors++;
      if (tr_v[n] !== exp_v[n]) begin
        miscompares++; $display("FAIL busy_start cyc%0d: got %b want %b", n, tr_v[n], exp_v[n]);
      end
    end
    vectors++;
    if (tr_round[31] !== 8'd1) begin
      miscompares++; $display("FAIL busy_start_round: got %0d want 1", tr_round[31]);
    end
  endtask

  task automatic test_mid_reset();
    set_cfg(9, 2, 9, 1, 1);
    run_seq(16, -1, -1, 12, 1'b0);
    clr_exp();
    exp_v[1][0] = 1'b1;
    exp_v[11][1] = 1'b1;
    exp_busy(1, 12);
    for (int n = 1; n <= 16; n++) begin
      vectors++;
      if (tr_v[n] !== exp_v[n]) begin
        miscompares++; $display("FAIL mid_reset cyc%0d: got %b want %b", n, tr_v[n], exp_v[n]);
      end
    end
    vectors++;
    if (tr_ts0[12] !== tr_stamp[10]) begin
      miscompares++; $display("FAIL mid_reset_ts0_pre: got %h want %h", tr_ts0[12], tr_stamp[10]);
    end
    vectors++;
    if (tr_ts0[13] !== '0) begin
      miscompares++; $display("FAIL mid_reset_ts0: got %h want 0", tr_ts0[13]);
    end
  endtask

  task automatic test_rounds_zero();
    set_cfg(9, 2, 9, 1, 0);
    run_seq(32, -1, -1, -1, 1'b0);
    build_basic();
    for (int n = 1; n <= 32; n++) begin
      vectors++;
      if (tr_v[n] !== exp_v[n]) begin
        miscompares++; $display("FAIL rounds0 cyc%0d: got %b want %b", n, tr_v[n], exp_v[n]);
      end
    end
    vectors++;
    if (tr_round[31] !== 8'd1) begin
      miscompares++; $display("FAIL rounds0_round: got %0d want 1", tr_round[31]);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_delay();
    test_rounds();
    test_abort();
    test_back_to_back();
    test_mid_reset();
    test_rounds_zero();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
